// File: rtl/lut_neuron_sweeper.sv
// lut_neuron_sweeper: drives every input code into one IN_W-input LUT neuron,
// captures its 1-bit output and streams the truth table as WORD_W-bit words
// over a single-register valid/ready port.
// Optional feature: define LUT_SWEEP_POPCNT_EN to append a trailer word
// carrying the number of ones captured during the sweep.
//
// state   | meaning
// IDLE    | waiting for start
// PROBE   | probe code on M0, wait counter loaded
// WAIT    | counting down neuron latency, capture at zero
// EMIT    | completed word held in output register until accepted
// TRAILER | popcount word held until accepted (LUT_SWEEP_POPCNT_EN only)
// DONE    | one-cycle done pulse, back to IDLE
module lut_neuron_sweeper #(
    parameter int IN_W   = 8,
    parameter int WORD_W = 32,
    parameter int LAT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_W-1:0]   M0,
    input  logic              M1,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_WAIT,
        S_EMIT,
`ifdef LUT_SWEEP_POPCNT_EN
        S_TRAILER,
`endif
        S_DONE
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   j;
    logic [CNT_W-1:0]  wait_cnt;
    logic [WORD_W-1:0] sreg;
    logic              capture;
    logic              word_end;
    logic              last_probe;
`ifdef LUT_SWEEP_POPCNT_EN
    logic [8:0]        pop;
`endif

    // M0[IN_W-1] toggles fastest: the probe code is the reversed index.
    function automatic logic [IN_W-1:0] bit_rev(input logic [IN_W-1:0] v);
        logic [IN_W-1:0] r;
        for (int i = 0; i < IN_W; i++) r[i] = v[IN_W-1-i];
        return r;
    endfunction

    assign word_end   = &j[BIT_W-1:0];
    assign last_probe = &j;

    // Capture happens once the neuron output for the current probe has settled.
    always_comb begin
        capture = 1'b0;
        if (state == S_PROBE && LAT == 0) capture = 1'b1;
        if (state == S_WAIT && wait_cnt == '0) capture = 1'b1;
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            j         <= '0;
            wait_cnt  <= '0;
            sreg      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            M0        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef LUT_SWEEP_POPCNT_EN
            pop       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        j     <= '0;
                        M0    <= bit_rev('0);
                        state <= S_PROBE;
`ifdef LUT_SWEEP_POPCNT_EN
                        pop   <= '0;
`endif
                    end
                end
                S_PROBE: begin
                    if (LAT != 0) begin
                        wait_cnt <= CNT_W'(LAT - 1);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (last_probe) begin
`ifdef LUT_SWEEP_POPCNT_EN
                            out_data <= {{(WORD_W-9){1'b0}}, pop};
                            out_last <= 1'b1;
                            state    <= S_TRAILER;
`else
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            j         <= j + 1'b1;
                            M0        <= bit_rev(j + 1'b1);
                            state     <= S_PROBE;
                        end
                    end
                end
`ifdef LUT_SWEEP_POPCNT_EN
                S_TRAILER: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // The word-completing bit goes straight into the output register.
            if (capture) begin
                sreg <= {M1, sreg[WORD_W-1:1]};
`ifdef LUT_SWEEP_POPCNT_EN
                pop  <= pop + 9'(M1);
`endif
                if (word_end) begin
                    out_data  <= {M1, sreg[WORD_W-1:1]};
                    out_valid <= 1'b1;
`ifdef LUT_SWEEP_POPCNT_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= last_probe;
`endif
                    state     <= S_EMIT;
                end else begin
                    j     <= j + 1'b1;
                    M0    <= bit_rev(j + 1'b1);
                    state <= S_PROBE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_sweeper.sv
// Directed bench for lut_neuron_sweeper: a LAT=0 instance with a combinational
// neuron and a LAT=2 instance with a two-stage registered neuron.
module tb_lut_neuron_sweeper;

`ifdef LUT_SWEEP_POPCNT_EN
    localparam int NW    = 9;
    localparam int EXTRA = 1;
`else
    localparam int NW    = 8;
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        start_a = 1'b0, ready_a = 1'b1, sel_a = 1'b0;
    logic        busy_a, done_a, m1_a, valid_a, last_a;
    logic [7:0]  m0_a;
    logic [31:0] data_a;

    logic        start_b = 1'b0, ready_b = 1'b1;
    logic        busy_b, done_b, m1_b, valid_b, last_b;
    logic [7:0]  m0_b;
    logic [31:0] data_b;
    logic        r1_b, r2_b;

    assign m1_a = sel_a ? m0_a[7] : m0_a[0];

    always @(posedge clk) begin
        r1_b <= m0_b[0];
        r2_b <= r1_b;
    end
    assign m1_b = r2_b;

    lut_neuron_sweeper #(.IN_W(8), .WORD_W(32), .LAT(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .M0(m0_a), .M1(m1_a), .out_data(data_a), .out_valid(valid_a),
        .out_ready(ready_a), .out_last(last_a)
    );

    lut_neuron_sweeper #(.IN_W(8), .WORD_W(32), .LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .M0(m0_b), .M1(m1_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready_b), .out_last(last_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [32:0] qa[$];
    logic [32:0] qb[$];
    int done_cnt_a = 0, done_cyc_a = 0, rise_a = 0;
    int done_cnt_b = 0, done_cyc_b = 0, rise_b = 0;
    logic busy_q_a = 1'b0, busy_q_b = 1'b0;

    // Handshake / done / busy-rise monitor using pre-edge values.
    always @(posedge clk) begin
        if (valid_a && ready_a) qa.push_back({last_a, data_a});
        if (valid_b && ready_b) qb.push_back({last_b, data_b});
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
        if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
        if (busy_a && !busy_q_a) rise_a = cyc;
        if (busy_b && !busy_q_b) rise_b = cyc;
        busy_q_a = busy_a;
        busy_q_b = busy_b;
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dcnt(input int which);
        return (which != 0) ? done_cnt_b : done_cnt_a;
    endfunction

    task automatic wait_done(input int which, input int budget);
        int base;
        int n;
        base = dcnt(which);
        n = 0;
        while (dcnt(which) == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dcnt(which) == base) begin
            checks++;
            errors++;
            $display("FAIL timeout_done: dut %0d no done within %0d cycles", which, budget);
        end
    endtask

    function automatic logic [31:0] exp_word(input int pat, input int i);
        if (i == 8) return 32'h0000_0080;
        if (pat == 1) return 32'hAAAA_AAAA;
        return (i < 4) ? 32'h0000_0000 : 32'hFFFF_FFFF;
    endfunction

    task automatic check_q(input string tag, input int pat, input int which);
        int sz;
        logic [32:0] e;
        sz = (which != 0) ? qb.size() : qa.size();
        check({tag, "_count"}, sz, NW);
        for (int i = 0; i < NW && i < sz; i++) begin
            e = (which != 0) ? qb[i] : qa[i];
            check({tag, "_word"}, e[31:0], exp_word(pat, i));
            check({tag, "_last"}, e[32], (i == NW - 1) ? 1'b1 : 1'b0);
        end
    endtask

    logic [7:0]  hold_exp [7] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h40};
    logic [31:0] d0;
    logic [7:0]  m0_hold;
    logic        l0, stable;
    int          base, n;

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_m0", m0_a, 8'h00);
        check("rst_data", data_a, 32'h0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_last", last_a, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Sweep with M1 = M0[0], LAT=0, sink always ready
        qa.delete();
        sel_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t1_busy_rise", busy_a, 1'b1);
        check("t1_first_m0", m0_a, 8'h00);
        wait_done(0, 1000);
        check("t1_duration", done_cyc_a - rise_a, 264 + EXTRA);
        check_q("t1", 0, 0);

        // M1 = M0[7] with start pulsed during the sweep and on the done cycle
        repeat (3) @(negedge clk);
        qa.delete();
        sel_a = 1'b1;
        base = done_cnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 1000) begin
            @(negedge clk);
            n++;
            start_a = ((n % 37) == 5);
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_done_once", done_cnt_a - base, 1);
        check("t2_idle_after", busy_a, 1'b0);
        check("t2_duration", done_cyc_a - rise_a, 264 + EXTRA);
        check_q("t2", 1, 0);

        // Back-pressure: sink stalls 20 cycles on the first word
        qa.delete();
        sel_a = 1'b0;
        ready_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!valid_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_valid_seen", valid_a, 1'b1);
        d0 = data_a;
        l0 = last_a;
        m0_hold = m0_a;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (data_a !== d0 || last_a !== l0 || m0_a !== m0_hold || valid_a !== 1'b1)
                stable = 1'b0;
            @(negedge clk);
        end
        ready_a = 1'b1;
        check("t3_stall_stable", stable, 1'b1);
        check("t3_stall_m0", m0_hold, 8'hF8);
        wait_done(0, 1000);
        check("t3_duration", done_cyc_a - rise_a, 284 + EXTRA);
        check_q("t3", 0, 0);

        // Reset in the middle of the sweep, at probe j=100 (M0 = 0x26)
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (m0_a !== 8'h26 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_j100", m0_a, 8'h26);
        base = done_cnt_a;
        rst = 1'b1;
        @(negedge clk);
        check("t4_busy", busy_a, 1'b0);
        check("t4_valid", valid_a, 1'b0);
        check("t4_m0", m0_a, 8'h00);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_no_done", done_cnt_a - base, 0);
        qa.delete();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 1000);
        check_q("t4", 0, 0);

        // LAT=2 with registered neuron M1 = M0[0]
        qb.delete();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("t5_m0_hold", m0_b, hold_exp[k]);
            @(negedge clk);
        end
        wait_done(1, 2000);
        check("t5_duration", done_cyc_b - rise_b, 776 + EXTRA);
        check_q("t5", 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
